// File: rtl/accel_csr_bank_if.sv
// CSR access bus for accel_csr_bank.
// Purpose : groups the register read/write port into one bundle.
// Signals : addr        - byte address of the access
//           ren / wen   - read / write strobes (may be asserted together)
//           wdata       - write data
//           rdata       - registered read data, valid the cycle after ren
//           raddr_error - registered with rdata, 1 when the read hit no register
//           waddr_error - one-cycle pulse after a write to no register
interface accel_csr_bank_if #(
    parameter int address_bits = 12,
    parameter int data_bits    = 64
) ();
    logic [address_bits-1:0] addr;
    logic                    ren;
    logic                    wen;
    logic [data_bits-1:0]    wdata;
    logic [data_bits-1:0]    rdata;
    logic                    raddr_error;
    logic                    waddr_error;

    modport master (
        output addr, ren, wen, wdata,
        input  rdata, raddr_error, waddr_error
    );

    modport slave (
        input  addr, ren, wen, wdata,
        output rdata, raddr_error, waddr_error
    );
endinterface

// File: rtl/accel_csr_bank.sv
// CSR bank controlling CHANNELS independent accelerator channels.
// Purpose : per channel, holds CTRL/STATUS/COUNT/INDEX/RESULT registers and
//           runs an IDLE -> REQ -> RUN handshake FSM launched by a START write.
// Ports   : clk, arst_n        - clock and synchronous active-low reset
//           csr                - CSR bus (slave side)
//           count_rsc_dat      - COUNT of channel n in slice n
//           index_rsc_dat      - INDEX of channel n in slice n (64 bits each)
//           go_vld / go_rdy    - per-channel launch handshake
//           done_vld / done_rdy, result_rsc_dat - per-channel completion
//           irq                - registered OR of the enabled DONE bits
module accel_csr_bank #(
    parameter int CHANNELS     = 2,
    parameter int address_bits = 12,
    parameter int data_bits    = 64,
    parameter int count_bits   = 23,
    parameter int result_bits  = 23
) (
    input  logic                            clk,
    input  logic                            arst_n,
    accel_csr_bank_if.slave                 csr,
    output logic [CHANNELS*count_bits-1:0]  count_rsc_dat,
    output logic [CHANNELS*64-1:0]          index_rsc_dat,
    output logic [CHANNELS-1:0]             go_vld,
    input  logic [CHANNELS-1:0]             go_rdy,
    input  logic [CHANNELS-1:0]             done_vld,
    output logic [CHANNELS-1:0]             done_rdy,
    input  logic [CHANNELS*result_bits-1:0] result_rsc_dat,
    output logic                            irq
);
    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RUN} state_e;
    typedef enum logic [2:0] {
        REG_CTRL, REG_STATUS, REG_COUNT, REG_INDEX, REG_RESULT, REG_IRQ, REG_NONE
    } reg_e;

    localparam logic [address_bits-1:0] IRQ_ADDR = address_bits'(CHANNELS * 64);

    state_e                  state_q [CHANNELS];
    state_e                  state_d [CHANNELS];
    logic [count_bits-1:0]   count_q [CHANNELS];
    logic [63:0]             index_q [CHANNELS];
    logic [result_bits-1:0]  result_q[CHANNELS];
    logic [CHANNELS-1:0]     irq_en_q, done_q, overrun_q;
    logic [CHANNELS-1:0]     busy, wr_sel, start_wr, irq_status;

    logic [address_bits-7:0] ch_sel;
    reg_e                    sel_reg;
    logic                    addr_err;
    logic [data_bits-1:0]    rd_val;

    // Address decode: the upper bits pick a 64-byte channel window, the low
    // six bits pick a register inside it. IRQ_STATUS sits just past the last
    // channel window.
    assign ch_sel = csr.addr[address_bits-1:6];

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        sel_reg = REG_NONE;
        if (csr.addr[2:0] == 3'b000) begin
            if (32'(ch_sel) < 32'(CHANNELS)) begin
                case (csr.addr[5:0])
                    6'h00:   sel_reg = REG_CTRL;
                    6'h08:   sel_reg = REG_STATUS;
                    6'h10:   sel_reg = REG_COUNT;
                    6'h18:   sel_reg = REG_INDEX;
                    6'h20:   sel_reg = REG_RESULT;
                    default: sel_reg = REG_NONE;
                endcase
            end else if (csr.addr == IRQ_ADDR) begin
                sel_reg = REG_IRQ;
            end
        end
    end

    assign addr_err = (sel_reg == REG_NONE);

    always_comb begin
        wr_sel   = '0;
        start_wr = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            wr_sel[c]   = csr.wen && !addr_err && (sel_reg != REG_IRQ)
                          && (32'(ch_sel) == 32'(c));
            start_wr[c] = wr_sel[c] && (sel_reg == REG_CTRL) && csr.wdata[0];
        end
    end

    // Channel FSM: state register.
    always_ff @(posedge clk) begin
        for (int c = 0; c < CHANNELS; c++) begin
            if (!arst_n) state_q[c] <= ST_IDLE;
            else         state_q[c] <= state_d[c];
        end
    end

    // Channel FSM: next state. A START seen outside IDLE leaves the FSM alone.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            state_d[c] = state_q[c];
            case (state_q[c])
                ST_IDLE: if (start_wr[c]) state_d[c] = ST_REQ;
                ST_REQ:  if (go_rdy[c])   state_d[c] = ST_RUN;
                ST_RUN:  if (done_vld[c]) state_d[c] = ST_IDLE;
                default:                  state_d[c] = ST_IDLE;
            endcase
        end
    end

    // Channel FSM: outputs. Handshakes are held low while reset is asserted
    // so nothing is offered before the state register has been cleared.
    always_comb begin
        go_vld   = '0;
        done_rdy = '0;
        busy     = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            go_vld[c]   = arst_n && (state_q[c] == ST_REQ);
            done_rdy[c] = arst_n && (state_q[c] == ST_RUN);
            busy[c]     = (state_q[c] != ST_IDLE);
        end
    end

    // Register file. The DONE set is placed after the W1C so it wins when
    // both land on the same edge.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            irq_en_q  <= '0;
            done_q    <= '0;
            overrun_q <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                count_q[c]  <= '0;
                index_q[c]  <= '0;
                result_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (wr_sel[c]) begin
                    case (sel_reg)
                        REG_CTRL: begin
                            irq_en_q[c] <= csr.wdata[1];
                            if (csr.wdata[0] && busy[c]) overrun_q[c] <= 1'b1;
                        end
                        REG_STATUS: begin
                            if (csr.wdata[1]) done_q[c]    <= 1'b0;
                            if (csr.wdata[2]) overrun_q[c] <= 1'b0;
                        end
                        // Operands are frozen while a transaction is in flight.
                        REG_COUNT: if (!busy[c]) count_q[c] <= csr.wdata[count_bits-1:0];
                        REG_INDEX: if (!busy[c]) index_q[c] <= 64'(csr.wdata);
                        default: ;
                    endcase
                end
                if (state_q[c] == ST_RUN && done_vld[c]) begin
                    done_q[c]   <= 1'b1;
                    result_q[c] <= result_rsc_dat[c*result_bits +: result_bits];
                end
            end
        end
    end

    assign irq_status = done_q & irq_en_q;

    // Read mux; unused upper bits and error addresses read as zero.
    always_comb begin
        rd_val = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (32'(ch_sel) == 32'(c)) begin
                case (sel_reg)
                    REG_CTRL:   rd_val = data_bits'({irq_en_q[c], 1'b0});
                    REG_STATUS: rd_val = data_bits'({overrun_q[c], done_q[c], busy[c]});
                    REG_COUNT:  rd_val = data_bits'(count_q[c]);
                    REG_INDEX:  rd_val = data_bits'(index_q[c]);
                    REG_RESULT: rd_val = data_bits'(result_q[c]);
                    default:    ;
                endcase
            end
        end
        if (sel_reg == REG_IRQ) rd_val = data_bits'(irq_status);
    end

    // Read data is sampled from the current register values, so a read that
    // coincides with a write returns the pre-write contents.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            csr.rdata       <= '0;
            csr.raddr_error <= 1'b0;
            csr.waddr_error <= 1'b0;
            irq             <= 1'b0;
        end else begin
            if (csr.ren) begin
                csr.rdata       <= rd_val;
                csr.raddr_error <= addr_err;
            end
            csr.waddr_error <= csr.wen && addr_err;
            irq             <= |irq_status;
        end
    end

    always_comb begin
        count_rsc_dat = '0;
        index_rsc_dat = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            count_rsc_dat[c*count_bits +: count_bits] = count_q[c];
            index_rsc_dat[c*64 +: 64]                 = index_q[c];
        end
    end
endmodule

// File: tb/tb_accel_csr_bank.sv
// Directed self-checking bench for accel_csr_bank with two channels.
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
module tb_accel_csr_bank;
    localparam int CH = 2;
    localparam int AB = 12;
    localparam int DB = 64;
    localparam int CB = 23;
    localparam int RB = 23;

    logic              clk = 1'b0;
    logic              arst_n;
    logic [CH*CB-1:0]  count_rsc_dat;
    logic [CH*64-1:0]  index_rsc_dat;
    logic [CH-1:0]     go_vld, go_rdy, done_vld, done_rdy;
    logic [CH*RB-1:0]  result_rsc_dat;
    logic              irq;

    int n_checks = 0;
    int n_fail   = 0;

    accel_csr_bank_if #(.address_bits(AB), .data_bits(DB)) csr_bus ();

    accel_csr_bank #(
        .CHANNELS(CH), .address_bits(AB), .data_bits(DB),
        .count_bits(CB), .result_bits(RB)
    ) dut (
        .clk            (clk),
        .arst_n         (arst_n),
        .csr            (csr_bus),
        .count_rsc_dat  (count_rsc_dat),
        .index_rsc_dat  (index_rsc_dat),
        .go_vld         (go_vld),
        .go_rdy         (go_rdy),
        .done_vld       (done_vld),
        .done_rdy       (done_rdy),
        .result_rsc_dat (result_rsc_dat),
        .irq            (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic csr_write(input logic [AB-1:0] a, input logic [DB-1:0] d);
        csr_bus.addr  = a;
        csr_bus.wdata = d;
        csr_bus.wen   = 1'b1;
        tick(1);
        csr_bus.wen   = 1'b0;
    endtask

    task automatic csr_read(input logic [AB-1:0] a, output logic [DB-1:0] d);
        csr_bus.addr = a;
        csr_bus.ren  = 1'b1;
        tick(1);
        csr_bus.ren  = 1'b0;
        d = csr_bus.rdata;
    endtask

    task automatic read_check(input string tag, input logic [AB-1:0] a, input logic [DB-1:0] exp);
        logic [DB-1:0] d;
        csr_read(a, d);
        check(tag, d, exp);
    endtask

    logic [DB-1:0] rd;
    logic [AB-1:0] zero_regs [11] = '{12'h000, 12'h008, 12'h010, 12'h018, 12'h020,
                                      12'h040, 12'h048, 12'h050, 12'h058, 12'h060,
                                      12'h080};

    initial begin
        arst_n         = 1'b0;
        go_rdy         = '0;
        done_vld       = '0;
        result_rsc_dat = '0;
        csr_bus.addr   = '0;
        csr_bus.ren    = 1'b0;
        csr_bus.wen    = 1'b0;
        csr_bus.wdata  = '0;
        tick(2);

        // Reset state
        check("rst_go_vld", 64'(go_vld), 64'h0);
        check("rst_done_rdy", 64'(done_rdy), 64'h0);
        check("rst_irq", 64'(irq), 64'h0);
        check("rst_rdata", csr_bus.rdata, 64'h0);
        check("rst_rerr", 64'(csr_bus.raddr_error), 64'h0);
        check("rst_werr", 64'(csr_bus.waddr_error), 64'h0);
        arst_n = 1'b1;
        tick(1);

        // Basic transaction on channel 0
        csr_write(12'h010, 64'd5);
        csr_write(12'h018, 64'h1000);
        check("count0_out", 64'(count_rsc_dat[0 +: CB]), 64'd5);
        check("index0_out", index_rsc_dat[0 +: 64], 64'h1000);
        csr_write(12'h000, 64'h3);
        check("ch0_go_vld", 64'(go_vld), 64'h1);
        check("ch0_done_rdy_req", 64'(done_rdy), 64'h0);
        read_check("status0_busy", 12'h008, 64'h1);
        tick(1);
        go_rdy[0] = 1'b1;
        tick(1);
        go_rdy[0] = 1'b0;
        check("ch0_go_vld_run", 64'(go_vld), 64'h0);
        check("ch0_done_rdy_run", 64'(done_rdy), 64'h1);
        tick(9);
        result_rsc_dat[0 +: RB] = 23'h2A;
        done_vld[0] = 1'b1;
        tick(1);
        done_vld[0] = 1'b0;
        check("ch0_done_rdy_idle", 64'(done_rdy), 64'h0);
        check("irq_lag", 64'(irq), 64'h0);
        tick(1);
        check("irq_set", 64'(irq), 64'h1);
        read_check("result0", 12'h020, 64'h2A);
        read_check("status0_done", 12'h008, 64'h2);
        read_check("irq_status_ch0", 12'h080, 64'h1);
        read_check("ctrl0", 12'h000, 64'h2);
        csr_write(12'h008, 64'h2);
        check("irq_hold", 64'(irq), 64'h1);
        tick(1);
        check("irq_clr", 64'(irq), 64'h0);
        read_check("status0_clr", 12'h008, 64'h0);

        // START and COUNT write while busy on channel 1
        csr_write(12'h050, 64'd7);
        csr_write(12'h040, 64'h1);
        csr_write(12'h040, 64'h1);
        csr_write(12'h050, 64'd9);
        read_check("status1_overrun", 12'h048, 64'h5);
        read_check("count1_kept", 12'h050, 64'd7);
        check("count1_out", 64'(count_rsc_dat[CB +: CB]), 64'd7);
        go_rdy[1] = 1'b1;
        tick(1);
        go_rdy[1] = 1'b0;
        result_rsc_dat[RB +: RB] = 23'h11;
        done_vld[1] = 1'b1;
        tick(1);
        done_vld[1] = 1'b0;
        read_check("status1_done_ovr", 12'h048, 64'h6);
        check("irq_masked", 64'(irq), 64'h0);
        csr_write(12'h048, 64'h6);
        read_check("status1_w1c", 12'h048, 64'h0);

        // Address errors
        read_check("count0_before_err", 12'h010, 64'd5);
        read_check("err_0x088_data", 12'h088, 64'h0);
        check("err_0x088_flag", 64'(csr_bus.raddr_error), 64'h1);
        tick(2);
        check("err_flag_held", 64'(csr_bus.raddr_error), 64'h1);
        read_check("err_0x004_data", 12'h004, 64'h0);
        check("err_0x004_flag", 64'(csr_bus.raddr_error), 64'h1);
        read_check("err_0x028_data", 12'h028, 64'h0);
        check("err_0x028_flag", 64'(csr_bus.raddr_error), 64'h1);
        read_check("irq_status_ok", 12'h080, 64'h0);
        check("ok_flag", 64'(csr_bus.raddr_error), 64'h0);
        csr_write(12'h0F8, 64'hFFFF);
        check("werr_pulse", 64'(csr_bus.waddr_error), 64'h1);
        tick(1);
        check("werr_drop", 64'(csr_bus.waddr_error), 64'h0);
        csr_write(12'h011, 64'h3);
        check("werr_misaligned", 64'(csr_bus.waddr_error), 64'h1);
        read_check("count0_untouched", 12'h010, 64'd5);

        // Simultaneous done on both channels with a DONE0 W1C
        csr_write(12'h000, 64'h3);
        csr_write(12'h040, 64'h3);
        go_rdy = 2'b11;
        tick(1);
        go_rdy = 2'b00;
        check("both_running", 64'(done_rdy), 64'h3);
        result_rsc_dat[0 +: RB]  = 23'h33;
        result_rsc_dat[RB +: RB] = 23'h44;
        done_vld = 2'b11;
        csr_write(12'h008, 64'h2);
        done_vld = 2'b00;
        read_check("status0_set_wins", 12'h008, 64'h2);
        read_check("status1_done", 12'h048, 64'h2);
        read_check("irq_status_both", 12'h080, 64'h3);
        check("irq_both", 64'(irq), 64'h1);
        read_check("result0_b", 12'h020, 64'h33);
        read_check("result1_b", 12'h060, 64'h44);
        csr_write(12'h000, 64'h3);
        read_check("status0_restart", 12'h008, 64'h3);
        go_rdy[0] = 1'b1;
        tick(1);
        go_rdy[0] = 1'b0;
        check("ch0_run_again", 64'(done_rdy), 64'h1);

        // Reset for one cycle in RUN
        arst_n = 1'b0;
        tick(1);
        arst_n = 1'b1;
        check("mid_rst_go_vld", 64'(go_vld), 64'h0);
        check("mid_rst_done_rdy", 64'(done_rdy), 64'h0);
        check("mid_rst_irq", 64'(irq), 64'h0);
        check("mid_rst_rdata", csr_bus.rdata, 64'h0);
        check("mid_rst_count_out", 64'(count_rsc_dat), 64'h0);
        result_rsc_dat[0 +: RB] = 23'h55;
        done_vld[0] = 1'b1;
        tick(1);
        done_vld[0] = 1'b0;
        for (int i = 0; i < 11; i++) begin
            read_check($sformatf("post_rst_0x%03h", zero_regs[i]), zero_regs[i], 64'h0);
        end

        // Field width limits
        csr_write(12'h010, 64'hFFFF_FFFF);
        read_check("count_trunc", 12'h010, 64'h7F_FFFF);
        csr_write(12'h018, 64'hDEAD_BEEF_0123_4567);
        read_check("index_full", 12'h018, 64'hDEAD_BEEF_0123_4567);

        // Read and write together return the pre-write value
        csr_bus.addr  = 12'h010;
        csr_bus.wdata = 64'h10;
        csr_bus.ren   = 1'b1;
        csr_bus.wen   = 1'b1;
        tick(1);
        csr_bus.ren   = 1'b0;
        csr_bus.wen   = 1'b0;
        check("rw_old_value", csr_bus.rdata, 64'h7F_FFFF);
        read_check("rw_new_value", 12'h010, 64'h10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
